// File: rtl/tdm_rx_deframer.sv
// tdm_rx_deframer
// Receive-side ST-bus deframer. Hunts for and locks onto frame alignment on
// the 2.048 Mb/s line, samples each bit in the second c4 cycle of its cell,
// assembles MSB-first channel bytes and queues {channel, byte} in a small
// registered-output FIFO drained by a valid/ready handshake.
//
// Ports
//   c4            4.096 MHz line clock, rising edge
//   reset_in_rg   synchronous active-high reset
//   f0            frame sync, active low
//   data_from_dt  serial TDM data, MSB of channel 0 first
//   ch_data       channel byte at FIFO head
//   ch_num        channel index of ch_data
//   ch_valid      FIFO head valid
//   ch_ready      consumer takes the head when ch_valid && ch_ready
//   locked        high while in LOCKED
//   frame_start   one-cycle pulse on each accepted f0 while LOCKED
//   lost_sync     one-cycle pulse when LOCKED is exited
//   overflow      sticky, a byte was dropped on a full FIFO
module tdm_rx_deframer #(
    parameter int unsigned CHANNELS   = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        c4,
    input  logic                        reset_in_rg,
    input  logic                        f0,
    input  logic                        data_from_dt,
    output logic [7:0]                  ch_data,
    output logic [$clog2(CHANNELS)-1:0] ch_num,
    output logic                        ch_valid,
    input  logic                        ch_ready,
    output logic                        locked,
    output logic                        frame_start,
    output logic                        lost_sync,
    output logic                        overflow
);

    localparam int unsigned FRAME_LEN = CHANNELS * 16;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN);
    localparam int unsigned CH_W      = $clog2(CHANNELS);
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W     = PTR_W + 1;
    localparam int unsigned ENTRY_W   = CH_W + 8;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [6:0]         shreg;
    logic               cnt_last_c;
    logic               frame_start_nx;
    logic               lost_sync_nx;
    logic               early_sync_c;
    logic               push_req_c;
    logic [ENTRY_W-1:0] push_entry_c;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic               pop_c;
    logic               full_c;
    logic               push_ok_c;
    logic               drop_c;
    logic [PTR_W-1:0]   rd_nx_c;
    logic [OCC_W-1:0]   occ_nx_c;
    logic [ENTRY_W-1:0] head_src_c;

    assign cnt_last_c = (cnt == CNT_W'(FRAME_LEN - 1));

    // Sync FSM next state and event pulses.
    always_comb begin
        state_nx       = state;
        frame_start_nx = 1'b0;
        lost_sync_nx   = 1'b0;
        early_sync_c   = 1'b0;
        case (state)
            ST_HUNT: begin
                if (!f0) begin
                    state_nx = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (cnt_last_c) begin
                    if (!f0) begin
                        state_nx       = ST_LOCKED;
                        frame_start_nx = 1'b1;
                    end else begin
                        state_nx = ST_HUNT;
                    end
                end
            end
            ST_LOCKED: begin
                if (!f0) begin
                    if (cnt_last_c) begin
                        frame_start_nx = 1'b1;
                    end else begin
                        // Early sync: realign, and the partial byte is discarded.
                        state_nx     = ST_CHECK;
                        lost_sync_nx = 1'b1;
                        early_sync_c = 1'b1;
                    end
                end else if (cnt_last_c) begin
                    state_nx     = ST_HUNT;
                    lost_sync_nx = 1'b1;
                end
            end
            default: begin
                state_nx = ST_HUNT;
            end
        endcase
    end

    // A channel completes on the edge ending its 16th cycle; only emit it when
    // alignment holds both before and after that edge.
    assign push_req_c   = (state == ST_LOCKED) && (state_nx == ST_LOCKED) &&
                          (cnt[3:0] == 4'hF);
    assign push_entry_c = {cnt[CNT_W-1:4], shreg, data_from_dt};

    // FSM state, event outputs, frame counter and bit shifter.
    always_ff @(posedge c4) begin
        if (reset_in_rg) begin
            state       <= ST_HUNT;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            lost_sync   <= 1'b0;
            cnt         <= '0;
            shreg       <= '0;
        end else begin
            state       <= state_nx;
            locked      <= (state_nx == ST_LOCKED);
            frame_start <= frame_start_nx;
            lost_sync   <= lost_sync_nx;
            if (!f0 || cnt_last_c) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (early_sync_c) begin
                shreg <= '0;
            end else if (cnt[0]) begin
                shreg <= {shreg[5:0], data_from_dt};
            end
        end
    end

    // FIFO control. A full FIFO still accepts a push when the head pops on the
    // same edge; the slot freed by the pop is the one being written.
    assign pop_c     = ch_valid && ch_ready;
    assign full_c    = (occ == OCC_W'(FIFO_DEPTH));
    assign push_ok_c = push_req_c && (!full_c || pop_c);
    assign drop_c    = push_req_c && full_c && !pop_c;
    assign rd_nx_c   = rd_ptr + PTR_W'(pop_c);
    assign occ_nx_c  = occ + OCC_W'(push_ok_c) - OCC_W'(pop_c);

    // Next head: bypass the incoming entry when it lands at the new read slot.
    assign head_src_c = (rd_nx_c == wr_ptr) ? push_entry_c : mem[rd_nx_c];

    // FIFO storage, no reset needed since occupancy guards every read.
    always_ff @(posedge c4) begin
        if (!reset_in_rg && push_ok_c) begin
            mem[wr_ptr] <= push_entry_c;
        end
    end

    // FIFO pointers, registered head and sticky overflow.
    always_ff @(posedge c4) begin
        if (reset_in_rg) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            ch_valid <= 1'b0;
            ch_data  <= '0;
            ch_num   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_nx_c;
            occ    <= occ_nx_c;
            if (drop_c) begin
                overflow <= 1'b1;
            end
            // Head only moves when empty or popped, so it is stable under stall.
            if (pop_c || !ch_valid) begin
                ch_valid <= (occ_nx_c != '0);
                if (occ_nx_c != '0) begin
                    {ch_num, ch_data} <= head_src_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_rx_deframer.sv
// Directed bench for tdm_rx_deframer: lock, capture, sync loss, early sync,
// backpressure/overflow, full-FIFO push+pop and mid-frame reset.
module tb_tdm_rx_deframer;

    localparam int L = 511;

    logic       c4;
    logic       reset_in_rg;
    logic       f0;
    logic       data_from_dt;
    logic [7:0] ch_data;
    logic [4:0] ch_num;
    logic       ch_valid;
    logic       ch_ready;
    logic       locked;
    logic       frame_start;
    logic       lost_sync;
    logic       overflow;

    int          checks = 0;
    int          errors = 0;
    int          pos;
    bit          skip_f0;
    bit          early_f0;
    logic [7:0]  bytes [32];
    logic [12:0] rx [$];

    tdm_rx_deframer #(.CHANNELS(32), .FIFO_DEPTH(4)) dut (
        .c4           (c4),
        .reset_in_rg  (reset_in_rg),
        .f0           (f0),
        .data_from_dt (data_from_dt),
        .ch_data      (ch_data),
        .ch_num       (ch_num),
        .ch_valid     (ch_valid),
        .ch_ready     (ch_ready),
        .locked       (locked),
        .frame_start  (frame_start),
        .lost_sync    (lost_sync),
        .overflow     (overflow)
    );

    initial begin
        c4 = 1'b0;
        forever #5 c4 = ~c4;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one c4 cycle of line data for frame position pos, record any
    // handshake taken on the edge, then advance pos the way the frame counter does.
    task automatic tick();
        int k;
        int c;
        k = pos / 2;
        c = k / 8;
        f0 = ((pos == L && !skip_f0) || early_f0) ? 1'b0 : 1'b1;
        data_from_dt = bytes[c][7 - (k % 8)];
        if (ch_valid && ch_ready && !reset_in_rg) rx.push_back({ch_num, ch_data});
        @(posedge c4);
        #1;
        if (f0 == 1'b0 || pos == L) pos = 0;
        else pos = pos + 1;
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while (pos != target && n < 2048) begin
            tick();
            n++;
        end
        if (pos != target) check("run_to_bound", 32'(pos), 32'(target));
    endtask

    initial begin
        for (int c = 0; c < 32; c++) bytes[c] = 8'(c * 37 + 11);
        bytes[0]  = 8'hA5;
        bytes[31] = 8'h3C;
        reset_in_rg  = 1'b1;
        ch_ready     = 1'b1;
        f0           = 1'b1;
        data_from_dt = 1'b0;
        skip_f0      = 1'b0;
        early_f0     = 1'b0;
        pos          = 400;

        // Reset state
        tick(); tick(); tick();
        check("rst_valid", 32'(ch_valid), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_ls", 32'(lost_sync), 32'd0);
        reset_in_rg = 1'b0;

        // Basic lock and capture
        run_to(L);
        tick();
        check("lock_first_f0", 32'(locked), 32'd0);
        run_to(L);
        check("lock_before_2nd", 32'(locked), 32'd0);
        tick();
        check("lock_2nd_f0", 32'(locked), 32'd1);
        check("lock_fs", 32'(frame_start), 32'd1);
        rx.delete();
        tick();
        check("fs_pulse_end", 32'(frame_start), 32'd0);
        run_to(15);
        check("ch0_not_yet", 32'(ch_valid), 32'd0);
        tick();
        check("ch0_valid", 32'(ch_valid), 32'd1);
        check("ch0_num", 32'(ch_num), 32'd0);
        check("ch0_data", 32'(ch_data), 32'hA5);
        run_to(L);
        tick();
        check("ch31_valid", 32'(ch_valid), 32'd1);
        check("ch31_num", 32'(ch_num), 32'd31);
        check("ch31_data", 32'(ch_data), 32'h3C);
        check("fs_locked", 32'(frame_start), 32'd1);
        tick();
        check("frame_count", 32'(rx.size()), 32'd32);
        for (int c = 0; c < 32; c++) check("frame_order", 32'(rx[c]), 32'({5'(c), bytes[c]}));

        // Missing sync
        run_to(L);
        skip_f0 = 1'b1;
        tick();
        skip_f0 = 1'b0;
        rx.delete();
        check("miss_ls", 32'(lost_sync), 32'd1);
        check("miss_locked", 32'(locked), 32'd0);
        check("miss_no_ch31", 32'(ch_valid), 32'd0);
        tick();
        check("miss_ls_end", 32'(lost_sync), 32'd0);
        run_to(L);
        tick();
        check("miss_check", 32'(locked), 32'd0);
        run_to(L);
        tick();
        check("miss_relock", 32'(locked), 32'd1);
        check("miss_relock_fs", 32'(frame_start), 32'd1);
        check("miss_no_bytes", 32'(rx.size()), 32'd0);

        // Early sync at cnt 200
        rx.delete();
        run_to(200);
        early_f0 = 1'b1;
        tick();
        early_f0 = 1'b0;
        check("early_ls", 32'(lost_sync), 32'd1);
        check("early_locked", 32'(locked), 32'd0);
        check("early_count", 32'(rx.size()), 32'd12);
        check("early_last", 32'(rx[11]), 32'({5'd11, bytes[11]}));
        run_to(L);
        check("early_no_ch12", 32'(rx.size()), 32'd12);
        check("early_empty", 32'(ch_valid), 32'd0);
        tick();
        check("early_relock", 32'(locked), 32'd1);

        // Backpressure for 100 cycles
        rx.delete();
        ch_ready = 1'b0;
        run_to(100);
        check("bp_valid", 32'(ch_valid), 32'd1);
        check("bp_hold_num", 32'(ch_num), 32'd0);
        check("bp_hold_data", 32'(ch_data), 32'(bytes[0]));
        check("bp_overflow", 32'(overflow), 32'd1);
        ch_ready = 1'b1;
        run_to(L);
        tick();
        tick();
        check("bp_count", 32'(rx.size()), 32'd30);
        check("bp_ch3", 32'(rx[3]), 32'({5'd3, bytes[3]}));
        check("bp_ch6", 32'(rx[4]), 32'({5'd6, bytes[6]}));
        check("bp_ch31", 32'(rx[29]), 32'({5'd31, 8'h3C}));
        check("bp_sticky", 32'(overflow), 32'd1);

        // Mid-operation reset with two entries queued
        run_to(260);
        ch_ready = 1'b0;
        run_to(300);
        check("mr_valid", 32'(ch_valid), 32'd1);
        check("mr_head", 32'(ch_num), 32'd16);
        reset_in_rg = 1'b1;
        tick();
        reset_in_rg = 1'b0;
        ch_ready = 1'b1;
        check("mr_valid0", 32'(ch_valid), 32'd0);
        check("mr_locked0", 32'(locked), 32'd0);
        check("mr_overflow0", 32'(overflow), 32'd0);
        check("mr_data0", 32'(ch_data), 32'd0);
        run_to(L);
        tick();
        check("mr_first_f0", 32'(locked), 32'd0);
        run_to(L);
        tick();
        check("mr_relock", 32'(locked), 32'd1);

        // Full FIFO, push and pop on the same edge
        rx.delete();
        ch_ready = 1'b0;
        run_to(79);
        check("ff_head", 32'(ch_num), 32'd0);
        check("ff_ovf_pre", 32'(overflow), 32'd0);
        ch_ready = 1'b1;
        tick();
        check("ff_ovf", 32'(overflow), 32'd0);
        check("ff_new_head", 32'(ch_num), 32'd1);
        run_to(L);
        tick();
        tick();
        check("ff_count", 32'(rx.size()), 32'd32);
        check("ff_ch4", 32'(rx[4]), 32'({5'd4, bytes[4]}));
        check("ff_ovf_end", 32'(overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
